// File: rtl/fire_pkg.sv
// Shared definitions for the fire-module post-accumulation stages.
// Provides the default widths, channel count and shift for fire3 expand1.
// It also provides the scalar types and a round/shift/saturate helper.
package fire_pkg;

  localparam int ACC_W          = 32;
  localparam int OUT_W          = 16;
  localparam int FIRE3_E1_CH    = 64;
  localparam int FIRE3_E1_SHIFT = 8;
  localparam int FIRE3_E1_CH_W  = $clog2(FIRE3_E1_CH);

  typedef logic signed [ACC_W-1:0]         acc_t;
  typedef logic signed [OUT_W-1:0]         act_t;
  typedef logic [FIRE3_E1_CH_W-1:0]        ch_idx_t;

  // Activation limits, sign-extended to the ACC_W+2 rounding intermediate.
  localparam logic signed [ACC_W+1:0] ACT_MAX_EXT =
    {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] ACT_MIN_EXT =
    {{(ACC_W+3-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // Round half up, arithmetic right shift, then saturate to the activation range.
  // A shift of zero passes the sum through to saturation without rounding.
  function automatic act_t sat_round(input logic signed [ACC_W:0] sum,
                                     input int unsigned shift);
    logic signed [ACC_W+1:0] ext;
    logic signed [ACC_W+1:0] half;
    logic signed [ACC_W+1:0] r;
    act_t                    res;
    ext = {sum[ACC_W], sum};
    if (shift != 32'd0) begin
      half = {{(ACC_W+1){1'b0}}, 1'b1} << (shift - 32'd1);
    end else begin
      half = {(ACC_W+2){1'b0}};
    end
    r = (ext + half) >>> shift;
    if (r > ACT_MAX_EXT) begin
      res = ACT_MAX_EXT[OUT_W-1:0];
    end else if (r < ACT_MIN_EXT) begin
      res = ACT_MIN_EXT[OUT_W-1:0];
    end else begin
      res = r[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bias_relu_fire3_expand1_requant_sat.sv
// Combinational requantizer: round half up, arithmetic shift by SHIFT,
// saturate to OUT_W signed, and optionally clamp negatives to zero.
// Optional feature macro: FIRE3_EXPAND1_RELU_EN (ReLU after saturation).
module requant_sat #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [ACC_W:0]   sum_i,
  output logic signed [OUT_W-1:0] data_o
);

  localparam int W = ACC_W + 2;

  localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [W-1:0] MAXV = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [W-1:0]     ext_s;
  logic signed [W-1:0]     shr_s;
  logic signed [OUT_W-1:0] sat_s;

  // The extra headroom bit keeps sum + HALF exact before the shift.
  assign ext_s = {sum_i[ACC_W], sum_i};
  assign shr_s = (ext_s + HALF) >>> SHIFT;

  // Clamp to the signed activation range.
  always_comb begin
    if (shr_s > MAXV) begin
      sat_s = MAXV[OUT_W-1:0];
    end else if (shr_s < MINV) begin
      sat_s = MINV[OUT_W-1:0];
    end else begin
      sat_s = shr_s[OUT_W-1:0];
    end
  end

  // ReLU on the saturated value when enabled, otherwise pass it through signed.
  always_comb begin
`ifdef FIRE3_EXPAND1_RELU_EN
    if (sat_s[OUT_W-1]) begin
      data_o = {OUT_W{1'b0}};
    end else begin
      data_o = sat_s;
    end
`else
    data_o = sat_s;
`endif
  end

endmodule

// File: rtl/bias_relu_fire3_expand1.sv
// fire3 expand1x1 post-accumulation: adds the per-channel bias, then requantizes.
// The requantize step rounds, shifts, saturates and optionally applies ReLU.
// Two register stages with a valid/ready handshake on both sides.
// Optional feature macro: FIRE3_EXPAND1_RELU_EN (see requant_sat).
module bias_relu_fire3_expand1 #(
  parameter int NUM_CH = fire_pkg::FIRE3_E1_CH,
  parameter int ACC_W  = fire_pkg::ACC_W,
  parameter int OUT_W  = fire_pkg::OUT_W,
  parameter int SHIFT  = fire_pkg::FIRE3_E1_SHIFT,
  parameter int CH_W   = $clog2(NUM_CH)   // derived from NUM_CH; leave at default
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0][ACC_W-1:0]  bias_mem,
  input  logic                          acc_valid,
  output logic                          acc_ready,
  input  logic signed [ACC_W-1:0]       acc_data,
  input  logic                          acc_sop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic [CH_W-1:0]               out_ch,
  output logic                          out_last,
  output logic                          sop_err
);

  import fire_pkg::*;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ZERO = {CH_W{1'b0}};
  localparam logic [CH_W-1:0] CH_ONE  = {{(CH_W-1){1'b0}}, 1'b1};

  // Channel tracking and sticky resync flag.
  logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
  logic            sop_err_q, sop_err_d;

  // Stage 1: exact biased sum.
  logic                  s1_valid_q, s1_valid_d;
  logic signed [ACC_W:0] s1_sum_q, s1_sum_d;
  logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
  logic                  s1_last_q, s1_last_d;

  // Stage 2: requantized output register.
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_last_q, out_last_d;

  logic                    s2_adv;
  logic                    acc_fire;
  logic [CH_W-1:0]         ch_use;
  logic [ACC_W-1:0]        bias_sel;
  logic signed [ACC_W:0]   sum_s;
  logic signed [OUT_W-1:0] rq_data;

  // S2 takes new data when empty or draining; S1 likewise when S2 takes its beat.
  assign s2_adv    = !out_valid_q || out_ready;
  assign acc_ready = !s1_valid_q || s2_adv;
  assign acc_fire  = acc_valid && acc_ready;

  // A sop beat is always channel 0, regardless of where the counter stands.
  assign ch_use   = acc_sop ? CH_ZERO : ch_cnt_q;
  assign bias_sel = bias_mem[ch_use];
  assign sum_s    = $signed({acc_data[ACC_W-1], acc_data})
                  + $signed({bias_sel[ACC_W-1], bias_sel});

  requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant_sat (
    .sum_i  (s1_sum_q),
    .data_o (rq_data)
  );

  // Next-state for the counter, sticky flag and both pipeline stages.
  always_comb begin
    ch_cnt_d    = ch_cnt_q;
    sop_err_d   = sop_err_q;
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_ch_d     = s1_ch_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;

    if (acc_fire) begin
      ch_cnt_d  = (ch_use == LAST_CH) ? CH_ZERO : (ch_use + CH_ONE);
      sop_err_d = sop_err_q | (acc_sop & (ch_cnt_q != CH_ZERO));
      s1_sum_d  = sum_s;
      s1_ch_d   = ch_use;
      s1_last_d = (ch_use == LAST_CH);
    end else begin
      ch_cnt_d  = ch_cnt_q;
      sop_err_d = sop_err_q;
    end

    if (acc_ready) begin
      s1_valid_d = acc_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = rq_data;
        out_ch_d   = s1_ch_q;
        out_last_d = s1_last_q;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards every in-flight beat and rewinds the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt_q    <= CH_ZERO;
      sop_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= {(ACC_W+1){1'b0}};
      s1_ch_q     <= CH_ZERO;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_ch_q    <= CH_ZERO;
      out_last_q  <= 1'b0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      sop_err_q   <= sop_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_ch_q     <= s1_ch_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign sop_err   = sop_err_q;

endmodule

// File: tb/tb_bias_relu_fire3_expand1.sv
// Scoreboard bench for bias_relu_fire3_expand1: stimulus pushes expected
// results into a queue, a negedge monitor pops and compares on each handshake.
module tb_bias_relu_fire3_expand1;

  localparam int NUM_CH = 64;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 8;

`ifdef FIRE3_EXPAND1_RELU_EN
  localparam logic [15:0] EXP_NEG3 = 16'd0;
  localparam logic [15:0] EXP_MIN  = 16'd0;
`else
  localparam logic [15:0] EXP_NEG3 = 16'hFFFD;   // -3
  localparam logic [15:0] EXP_MIN  = 16'h8000;   // -32768
`endif

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_CH-1:0][ACC_W-1:0] bias_mem;
  logic                         acc_valid;
  logic                         acc_ready;
  logic signed [ACC_W-1:0]      acc_data;
  logic                         acc_sop;
  logic                         out_valid;
  logic                         out_ready = 1'b1;
  logic signed [OUT_W-1:0]      out_data;
  logic [5:0]                   out_ch;
  logic                         out_last;
  logic                         sop_err;

  typedef struct packed {
    logic [15:0] d;
    logic [5:0]  ch;
    logic        last;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  int     tb_ch  = 0;
  bit     hold   = 1'b0;
  bit     bp_en  = 1'b0;
  longint bias_tb[NUM_CH];

  bias_relu_fire3_expand1 #(
    .NUM_CH (NUM_CH), .ACC_W (ACC_W), .OUT_W (OUT_W), .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bias_mem  (bias_mem),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .acc_sop   (acc_sop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .sop_err   (sop_err)
  );

  always #5 clk = ~clk;

  // Downstream ready: forced low, random 30% duty, or always high.
  always @(posedge clk) begin
    #1;
    if (hold) out_ready = 1'b0;
    else if (bp_en) out_ready = ($urandom_range(0, 99) < 30);
    else out_ready = 1'b1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference requantization: bias add, round half up, shift, saturate, ReLU.
  function automatic logic [15:0] model(input longint acc, input longint b);
    longint s;
    s = acc + b + 128;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef FIRE3_EXPAND1_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[15:0];
  endfunction

  // Monitor: pop on each handshake; also checks stability across stalls.
  exp_t e_mon;
  exp_t held;
  bit   stall_q = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_data, out_ch, out_last}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got data=%0d ch=%0d, required no output",
                   out_data, out_ch);
        end else begin
          e_mon = exp_q.pop_front();
          chk("out_data", out_data, $signed(e_mon.d));
          chk("out_ch", out_ch, e_mon.ch);
          chk("out_last", out_last, e_mon.last);
        end
      end
      stall_q = out_valid && !out_ready;
      held    = {out_data, out_ch, out_last};
    end
  end

  // Drive one beat; call at posedge+1, returns at posedge+1 after acceptance.
  task automatic send(input int acc, input bit sop, input bit push,
                      input bit hand, input logic [15:0] hv);
    int   ch;
    int   waited;
    bit   ok;
    exp_t e;
    ch     = sop ? 0 : tb_ch;
    tb_ch  = (ch == NUM_CH - 1) ? 0 : ch + 1;
    e.d    = hand ? hv : model(acc, bias_tb[ch]);
    e.ch   = ch[5:0];
    e.last = (ch == NUM_CH - 1);
    acc_valid = 1'b1;
    acc_data  = acc;
    acc_sop   = sop;
    ok     = 1'b0;
    waited = 0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (acc_ready) begin
        ok = 1'b1;
        if (push) exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    acc_valid = 1'b0;
    acc_sop   = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got acc_ready=0 for 200 cycles, required 1");
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 4000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic fill_to_zero(input int acc);
    while (tb_ch != 0) send(acc, 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) bias_tb[i] = (i - 32) * 8;
    bias_tb[0]  = -321;
    bias_tb[1]  = 290;
    bias_tb[63] = 0;
    for (int i = 0; i < NUM_CH; i++) bias_mem[i] = bias_tb[i][31:0];
    rst_n = 1'b0;
    acc_valid = 1'b0;
    acc_data  = '0;
    acc_sop   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sop_err", sop_err, 0);
    chk("rst_acc_ready", acc_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;

    // Bias and round: 1000-321=679 -> 3; -1000+290=-710 -> -3 (0 with ReLU).
    send(1000, 1'b1, 1'b1, 1'b1, 16'd3);
    chk("latency_cycle1", out_valid, 0);
    @(posedge clk);
    #1;
    chk("latency_cycle2", out_valid, 1);
    send(-1000, 1'b0, 1'b1, 1'b1, EXP_NEG3);
    for (int c = 2; c < NUM_CH; c++) send(c * 5000 - 150000, 1'b0, 1'b1, 1'b0, 16'd0);

    // Saturation at both ends.
    send(32'h80000000, 1'b1, 1'b1, 1'b1, EXP_MIN);
    send(32'h7FFFFF00, 1'b0, 1'b1, 1'b1, 16'h7FFF);
    fill_to_zero(-77777);

    // Wrap and last: ch63 with bias 0 gives (256+128)>>8 = 1; 65th beat is ch0.
    send(256, 1'b1, 1'b1, 1'b0, 16'd0);
    for (int c = 1; c < NUM_CH - 1; c++) send(256, 1'b0, 1'b1, 1'b0, 16'd0);
    send(256, 1'b0, 1'b1, 1'b1, 16'd1);
    send(256, 1'b0, 1'b1, 1'b0, 16'd0);
    fill_to_zero(256);
    drain();

    // Backpressure: 1000 beats with random downstream ready.
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(int'($urandom_range(0, 200000)) - 100000, (i % 64) == 0, 1'b1, 1'b0, 16'd0);
    fill_to_zero(12345);
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    chk("sop_err_clean", sop_err, 0);

    // Resync: sop on the 10th beat lands on ch0 and sets the sticky flag.
    send(400, 1'b1, 1'b1, 1'b0, 16'd0);
    for (int i = 1; i < 9; i++) send(400 + i, 1'b0, 1'b1, 1'b0, 16'd0);
    send(500, 1'b1, 1'b1, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sop_err_set", sop_err, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("sop_err_sticky", sop_err, 1);
    drain();

    // Reset with two beats in flight: both discarded, counter back to 0.
    hold = 1'b1;
    @(posedge clk);
    #1;
    send(700, 1'b0, 1'b0, 1'b0, 16'd0);
    send(701, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("inflight_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sop_err", sop_err, 0);
    tb_ch = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hold  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_no_output", out_valid, 0);
    send(256, 1'b0, 1'b1, 1'b0, 16'd0);
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
